// File: rtl/wordle_guess_scorer.sv
// Scores one five-letter guess against a target word and streams the five
// green/yellow/white colors into a color array, one column per cycle.
module wordle_guess_scorer #(
  parameter int         NROWS    = 6,
  parameter logic [2:0] C_GREEN  = 3'b010,
  parameter logic [2:0] C_YELLOW = 3'b110,
  parameter logic [2:0] C_WHITE  = 3'b111
) (
  input  logic        Clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic [39:0] guess,
  input  logic [39:0] target,
  input  logic [2:0]  row,
  output logic        busy,
  output logic        cw_en,
  output logic [2:0]  cw_row,
  output logic [2:0]  cw_col,
  output logic [2:0]  cw_color,
  output logic        done,
  output logic        win,
  output logic        err
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_GREEN  = 3'd1;
  localparam logic [2:0] S_YELLOW = 3'd2;
  localparam logic [2:0] S_WRITE  = 3'd3;
  localparam logic [2:0] S_DONE   = 3'd4;

  localparam logic [3:0] NROWS_W = 4'(NROWS);

  logic [2:0] state_q;
  logic [2:0] i_q;
  logic [4:0] used_q;
  logic [2:0] color_q [5];
  logic [7:0] gss_q [5];
  logic [7:0] tgt_q [5];
  logic [2:0] row_q;
  logic       err_q;

  logic       req_ok;
  logic       accept;
  logic       last;
  logic       y_hit;
  logic [2:0] y_idx;
  logic       all_green;

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    req_ok = ({1'b0, row} < NROWS_W);
    for (int k = 0; k < 5; k++) begin
      if (guess[39-8*k -: 8] < 8'h41 || guess[39-8*k -: 8] > 8'h5A) req_ok = 1'b0;
    end
  end

  assign accept = (state_q == S_IDLE) && start && req_ok;
  assign last   = (i_q == 3'd4);

  // Scanning from the top down leaves the lowest matching unused position.
  always_comb begin
    y_hit = 1'b0;
    y_idx = 3'd0;
    for (int j = 4; j >= 0; j--) begin
      if (!used_q[j] && tgt_q[j] == gss_q[i_q]) begin
        y_hit = 1'b1;
        y_idx = j[2:0];
      end
    end
  end

  always_comb begin
    all_green = 1'b1;
    for (int k = 0; k < 5; k++) begin
      if (color_q[k] != C_GREEN) all_green = 1'b0;
    end
  end

  // NOTE: the captured job data needs no reset; it is only read after an
  // accepted start has loaded it, so it lives in its own reset-free block.
  always_ff @(posedge Clk) begin
    if (accept) begin
      for (int k = 0; k < 5; k++) begin
        gss_q[k] <= guess[39-8*k -: 8];
        tgt_q[k] <= target[39-8*k -: 8];
      end
      row_q <= row;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge Clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      i_q     <= 3'd0;
      used_q  <= '0;
      err_q   <= 1'b0;
      for (int k = 0; k < 5; k++) color_q[k] <= 3'd0;
    end else begin
      err_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start && !req_ok) begin
            err_q <= 1'b1;
          end else if (accept) begin
            state_q <= S_GREEN;
            i_q     <= 3'd0;
            used_q  <= '0;
            for (int k = 0; k < 5; k++) color_q[k] <= 3'd0;
          end
        end
        S_GREEN: begin
          if (gss_q[i_q] == tgt_q[i_q]) begin
            color_q[i_q] <= C_GREEN;
            used_q[i_q]  <= 1'b1;
          end else begin
            color_q[i_q] <= C_WHITE;
          end
          i_q <= last ? 3'd0 : i_q + 3'd1;
          if (last) state_q <= S_YELLOW;
        end
        S_YELLOW: begin
          if (color_q[i_q] != C_GREEN && y_hit) begin
            color_q[i_q]  <= C_YELLOW;
            used_q[y_idx] <= 1'b1;
          end
          i_q <= last ? 3'd0 : i_q + 3'd1;
          if (last) state_q <= S_WRITE;
        end
        S_WRITE: begin
          i_q <= last ? 3'd0 : i_q + 3'd1;
          if (last) state_q <= S_DONE;
        end
        S_DONE:  state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Outputs decode straight from state so reset clears them asynchronously.
  assign busy     = (state_q != S_IDLE);
  assign cw_en    = (state_q == S_WRITE);
  assign cw_row   = cw_en ? row_q : 3'd0;
  assign cw_col   = cw_en ? i_q : 3'd0;
  assign cw_color = cw_en ? color_q[i_q] : 3'd0;
  assign done     = (state_q == S_DONE);
  assign win      = done && all_green;
  assign err      = err_q;

endmodule

// File: tb/tb_wordle_guess_scorer.sv
// Scoreboard bench for wordle_guess_scorer: expected color-array writes are
// queued at start and popped as cw_en strobes appear.
module tb_wordle_guess_scorer;

  localparam logic [2:0] G = 3'b010;
  localparam logic [2:0] Y = 3'b110;
  localparam logic [2:0] W = 3'b111;

  logic        Clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic [39:0] guess = '0;
  logic [39:0] target = '0;
  logic [2:0]  row = '0;
  logic        busy, cw_en, done, win, err;
  logic [2:0]  cw_row, cw_col, cw_color;

  typedef struct packed {
    logic [2:0] r;
    logic [2:0] c;
    logic [2:0] col;
  } wr_t;

  wr_t wq[$];
  int  vectors = 0;
  int  miscompares = 0;

  wordle_guess_scorer dut (
    .Clk(Clk), .reset_n(reset_n), .start(start), .guess(guess), .target(target),
    .row(row), .busy(busy), .cw_en(cw_en), .cw_row(cw_row), .cw_col(cw_col),
    .cw_color(cw_color), .done(done), .win(win), .err(err)
  );

  always #5 Clk = ~Clk;

  function automatic logic [14:0] score_ref(input logic [39:0] g, input logic [39:0] t);
    logic [7:0] gb [5];
    logic [7:0] tb_ [5];
    bit         used [5];
    logic [2:0] col [5];
    logic [14:0] res;
    bit         found;
    res = '0;
    for (int k = 0; k < 5; k++) begin
      gb[k] = g[39-8*k -: 8];
      tb_[k] = t[39-8*k -: 8];
      used[k] = 1'b0;
    end
    for (int k = 0; k < 5; k++) begin
      if (gb[k] == tb_[k]) begin col[k] = G; used[k] = 1'b1; end
      else col[k] = W;
    end
    for (int k = 0; k < 5; k++) begin
      if (col[k] != G) begin
        found = 1'b0;
        for (int j = 0; j < 5; j++) begin
          if (!found && !used[j] && tb_[j] == gb[k]) begin
            found = 1'b1; used[j] = 1'b1; col[k] = Y;
          end
        end
      end
    end
    for (int k = 0; k < 5; k++) res[14-3*k -: 3] = col[k];
    return res;
  endfunction

  task automatic check_idle_outputs(input string name);
    vectors++;
    if ({busy, cw_en, cw_row, cw_col, cw_color, done, win, err} !== 14'd0) begin
      miscompares++;
      $display("FAIL %s: outputs=%b required all zero", name,
               {busy, cw_en, cw_row, cw_col, cw_color, done, win, err});
    end
  endtask

  task automatic test_reset;
    reset_n = 1'b0;
    #1;
    check_idle_outputs("reset_state");
    @(negedge Clk);
    reset_n = 1'b1;
  endtask

  // Runs one accepted job, checking every cycle from 1 to 17.
  task automatic run_job(input logic [39:0] g, input logic [39:0] t, input logic [2:0] r,
                         input logic [14:0] exp_cols, input bit retrig, input string name);
    wr_t e;
    bit  exp_win;
    exp_win = (exp_cols == {5{G}});
    @(negedge Clk);
    guess = g; target = t; row = r; start = 1'b1;
    for (int c = 0; c < 5; c++) begin
      e.r = r; e.c = c[2:0]; e.col = exp_cols[14-3*c -: 3];
      wq.push_back(e);
    end
    for (int cyc = 1; cyc <= 17; cyc++) begin
      @(negedge Clk);
      vectors++;
      if (busy !== (cyc <= 16)) begin
        miscompares++;
        $display("FAIL %s busy cyc%0d: got %b required %b", name, cyc, busy, cyc <= 16);
      end
      if (err !== 1'b0) begin
        miscompares++;
        $display("FAIL %s err cyc%0d: got %b required 0", name, cyc, err);
      end
      if (cw_en !== (cyc >= 11 && cyc <= 15)) begin
        miscompares++;
        $display("FAIL %s cw_en cyc%0d: got %b required %b", name, cyc, cw_en,
                 (cyc >= 11 && cyc <= 15));
      end
      if (cw_en === 1'b1) begin
        if (wq.size() == 0) begin
          miscompares++;
          $display("FAIL %s extra_write cyc%0d: got write with empty queue", name, cyc);
        end else begin
          e = wq.pop_front();
          if ({cw_row, cw_col, cw_color} !== e) begin
            miscompares++;
            $display("FAIL %s write cyc%0d: got row=%0d col=%0d color=%b required row=%0d col=%0d color=%b",
                     name, cyc, cw_row, cw_col, cw_color, e.r, e.c, e.col);
          end
        end
      end
      if (done !== (cyc == 16)) begin
        miscompares++;
        $display("FAIL %s done cyc%0d: got %b required %b", name, cyc, done, cyc == 16);
      end
      if (cyc == 16 && win !== exp_win) begin
        miscompares++;
        $display("FAIL %s win: got %b required %b", name, win, exp_win);
      end
      start  = retrig && (cyc == 3 || cyc == 9);
      guess  = {$urandom, 8'h5A};
      target = {$urandom, 8'h41};
      row    = 3'($urandom);
    end
    start = 1'b0;
    vectors++;
    if (wq.size() != 0) begin
      miscompares++;
      $display("FAIL %s missing_writes: got %0d left in queue required 0", name, wq.size());
    end
    wq.delete();
  endtask

  task automatic test_reject(input logic [39:0] g, input logic [39:0] t, input logic [2:0] r,
                             input string name);
    @(negedge Clk);
    guess = g; target = t; row = r; start = 1'b1;
    @(negedge Clk);
    start = 1'b0;
    vectors++;
    if ({err, busy, cw_en, done} !== 4'b1000) begin
      miscompares++;
      $display("FAIL %s cyc1: got err/busy/cw_en/done=%b required 1000", name, {err, busy, cw_en, done});
    end
    for (int cyc = 2; cyc <= 4; cyc++) begin
      @(negedge Clk);
      vectors++;
      if ({err, busy, cw_en, done} !== 4'b0000) begin
        miscompares++;
        $display("FAIL %s cyc%0d: got err/busy/cw_en/done=%b required 0000", name, cyc,
                 {err, busy, cw_en, done});
      end
    end
  endtask

  task automatic test_basic;
    run_job("CRANE", "CRANE", 3'd0, {G, G, G, G, G}, 1'b0, "crane_win");
    run_job("BOBBY", "ABBEY", 3'd2, {Y, W, G, W, G}, 1'b0, "bobby_abbey");
    run_job("AZAZA", "ZAZAZ", 3'd4, score_ref("AZAZA", "ZAZAZ"), 1'b0, "letter_bounds");
  endtask

  task automatic test_errors;
    test_reject("CR NE", "CRANE", 3'd0, "bad_space");
    test_reject("@RANE", "CRANE", 3'd1, "bad_low");
    test_reject("CRAN[", "CRANE", 3'd1, "bad_high");
    test_reject("CRANE", "CRANE", 3'd6, "bad_row6");
    test_reject("CRANE", "CRANE", 3'd7, "bad_row7");
    run_job("NACRE", "CRANE", 3'd5, score_ref("NACRE", "CRANE"), 1'b0, "row5_after_reject");
  endtask

  task automatic test_retrigger;
    run_job("EERIE", "THERE", 3'd1, score_ref("EERIE", "THERE"), 1'b1, "retrigger");
  endtask

  task automatic test_reset_mid;
    @(negedge Clk);
    guess = "CRANE"; target = "CRANE"; row = 3'd3; start = 1'b1;
    for (int cyc = 1; cyc <= 12; cyc++) begin
      @(negedge Clk);
      start = 1'b0;
    end
    vectors++;
    if (cw_en !== 1'b1) begin
      miscompares++;
      $display("FAIL mid_reset_prewrite: got cw_en=%b required 1", cw_en);
    end
    #2 reset_n = 1'b0;
    #1;
    check_idle_outputs("mid_reset_async");
    for (int cyc = 0; cyc < 6; cyc++) begin
      @(negedge Clk);
      check_idle_outputs("mid_reset_hold");
    end
    reset_n = 1'b1;
    wq.delete();
    run_job("CRANE", "CRANE", 3'd3, {G, G, G, G, G}, 1'b0, "after_reset");
  endtask

  task automatic test_random;
    logic [39:0] g, t;
    for (int n = 0; n < 6; n++) begin
      for (int k = 0; k < 5; k++) begin
        g[39-8*k -: 8] = 8'h41 + 8'($urandom_range(0, 3));
        t[39-8*k -: 8] = 8'h41 + 8'($urandom_range(0, 3));
      end
      run_job(g, t, 3'($urandom_range(0, 5)), score_ref(g, t), 1'b0, "random");
    end
  endtask

  task automatic test_back_to_back;
    run_job("ABBEY", "BOBBY", 3'd1, score_ref("ABBEY", "BOBBY"), 1'b0, "b2b_first");
    run_job("ABBEY", "ABBEY", 3'd2, {G, G, G, G, G}, 1'b0, "b2b_second");
  endtask

  initial begin
    test_reset();
    test_basic();
    test_errors();
    test_retrigger();
    test_reset_mid();
    test_random();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
